// File: rtl/audio_pkg.sv
// Shared definitions for the CODEC audio capture path: receiver FSM encoding,
// default sample width and I2S channel constants.
package audio_pkg;

    localparam int SAMPLE_W_DEF = 16;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SKIP      = 2'd1,
        SHIFT     = 2'd2,
        PAD       = 2'd3
    } rx_state_e;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

endpackage

// File: rtl/audio_adc_rx_if.sv
// Frame handshake between the I2S receiver (master) and its consumer (slave):
// stereo samples, level byte, valid/ack and the sticky overrun flag.
interface audio_adc_rx_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

    logic                i_ack;
    logic [SAMPLE_W-1:0] o_left;
    logic [SAMPLE_W-1:0] o_right;
    logic                o_valid;
    logic                o_overrun;
    logic [7:0]          o_level;

    modport master (
        input  i_ack,
        output o_left, o_right, o_valid, o_overrun, o_level
    );

    modport slave (
        output i_ack,
        input  o_left, o_right, o_valid, o_overrun, o_level
    );

endinterface

// File: rtl/audio_in_sync.sv
// Multi-flop synchronizer for one CODEC serial line, with a rising-edge
// detector on the synchronized value.
module audio_in_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_d};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    assign o_q    = r_sync[SYNC_STG-1];
    assign o_rise = o_q & ~r_prev;

endmodule

// File: rtl/audio_adc_rx.sv
// I2S capture receiver: oversamples BCLK/LRCK/DAT in the clk domain, deserializes
// left/right words and hands complete stereo frames over a valid/ack interface.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic           clk,
    input  logic           iRST_N,
    input  logic           AUD_BCLK,
    input  logic           AUD_ADCLRCK,
    input  logic           AUD_ADCDAT,
    input  logic           i_en,
    audio_adc_rx_if.master bus
);

    localparam int              CNT_W    = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

    logic w_bclk_q, w_bclk_rise;
    logic w_lr, w_lr_rise;
    logic w_dat, w_dat_rise;

    audio_in_sync #(.SYNC_STG(SYNC_STG)) u_sync_bclk (
        .clk(clk), .i_rst_n(iRST_N), .i_d(AUD_BCLK), .o_q(w_bclk_q), .o_rise(w_bclk_rise)
    );
    audio_in_sync #(.SYNC_STG(SYNC_STG)) u_sync_lrck (
        .clk(clk), .i_rst_n(iRST_N), .i_d(AUD_ADCLRCK), .o_q(w_lr), .o_rise(w_lr_rise)
    );
    audio_in_sync #(.SYNC_STG(SYNC_STG)) u_sync_dat (
        .clk(clk), .i_rst_n(iRST_N), .i_d(AUD_ADCDAT), .o_q(w_dat), .o_rise(w_dat_rise)
    );

    rx_state_e           r_state, w_state_nxt;
    logic                r_ch, w_ch_nxt;
    logic [CNT_W-1:0]    r_bitcnt, w_bitcnt_nxt;
    logic [SAMPLE_W-2:0] r_shift, w_shift_nxt;
    logic [SAMPLE_W-1:0] w_word;
    logic                r_lr_last;
    logic                w_lr_chg;
    logic                w_store;
    logic [SAMPLE_W-1:0] r_hold_l, r_hold_r;
    logic                r_frame_done;

    assign w_word   = {r_shift, w_dat};
    // LRCK moves on the BCLK falling edge, so a slot boundary is acted on as soon as it
    // is seen; the one-bit-delay bit at the next rise then lands in SKIP.
    assign w_lr_chg = (w_lr != r_lr_last);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_store      = 1'b0;
        if (!i_en) begin
            w_state_nxt = WAIT_SYNC;
        end else begin
            case (r_state)
                WAIT_SYNC: if (w_lr_chg && (w_lr == CH_L)) begin
                    w_ch_nxt    = CH_L;
                    w_state_nxt = SKIP;
                end
                SKIP: if (w_bclk_rise) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = SHIFT;
                end
                SHIFT: if (w_lr_chg) begin
                    w_ch_nxt    = w_lr;
                    w_state_nxt = SKIP;
                end else if (w_bclk_rise) begin
                    w_shift_nxt  = w_word[SAMPLE_W-2:0];
                    w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
                    if (r_bitcnt == LAST_BIT) begin
                        w_store     = 1'b1;
                        w_state_nxt = PAD;
                    end
                end
                PAD: if (w_lr_chg) begin
                    w_ch_nxt    = w_lr;
                    w_state_nxt = SKIP;
                end
                default: w_state_nxt = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state      <= WAIT_SYNC;
            r_ch         <= CH_L;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_lr_last    <= 1'b0;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch         <= w_ch_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            if (w_bclk_rise) r_lr_last <= w_lr;
            if (w_store && (r_ch == CH_L)) r_hold_l <= w_word;
            if (w_store && (r_ch == CH_R)) r_hold_r <= w_word;
            r_frame_done <= w_store && (r_ch == CH_R);
        end
    end

    // Level: |left| with one guard bit so the most negative sample saturates.
    logic [SAMPLE_W:0] w_sext, w_abs;
    logic [7:0]        w_level;

    assign w_sext  = {r_hold_l[SAMPLE_W-1], r_hold_l};
    assign w_abs   = w_sext[SAMPLE_W] ? (~w_sext + (SAMPLE_W+1)'(1)) : w_sext;
    assign w_level = (w_abs[SAMPLE_W] | w_abs[SAMPLE_W-1]) ? 8'hFF : w_abs[SAMPLE_W-2 -: 8];

    logic [SAMPLE_W-1:0] r_left, r_right;
    logic                r_valid, r_overrun;
    logic [7:0]          r_level;

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_left    <= '0;
            r_right   <= '0;
            r_level   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!i_en) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_frame_done) begin
            r_left  <= r_hold_l;
            r_right <= r_hold_r;
            r_level <= w_level;
            r_valid <= 1'b1;
            if (r_valid && !bus.i_ack) r_overrun <= 1'b1;
        end else if (bus.i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.o_left    = r_left;
    assign bus.o_right   = r_right;
    assign bus.o_level   = r_level;
    assign bus.o_valid   = r_valid;
    assign bus.o_overrun = r_overrun;

    logic w_unused;
    assign w_unused = ^{w_bclk_q, w_lr_rise, w_dat_rise, w_abs[SAMPLE_W-10:0]};

endmodule
